// File: rtl/vector_pkg.sv
// Shared types and constants for the bit-ordered vector stream.
// The serializer and its matching receiver both import this package.
package vector_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic ORDER_MSB_FIRST = 1'b0;
    localparam logic ORDER_LSB_FIRST = 1'b1;

endpackage

// File: rtl/vector_serializer.sv
// Parallel-to-serial transmitter: one WIDTH-bit word per handshake,
// driven out one bit per clock in the order chosen with the word.
module vector_serializer
    import vector_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             lsb_first,
    output logic             din_ready,
    output logic             sdo,
    output logic             sdo_valid,
    output logic             sdo_last
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             order_q, order_d;
    logic             accept;

    assign sdo_last  = (state_q == SHIFT) && (cnt_q == LAST_CNT);
    assign sdo_valid = (state_q == SHIFT);
    assign din_ready = rst_n && ((state_q == IDLE) || sdo_last);
    assign accept    = din_valid && din_ready;

    // The output end depends on the order latched with the word
    always_comb begin
        sdo = 1'b0;
        if (state_q == SHIFT) begin
            sdo = (order_q == ORDER_LSB_FIRST) ? shift_q[0]
                                               : shift_q[WIDTH-1];
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        order_d = order_q;
        if (accept) begin
            state_d = SHIFT;
            shift_d = din;
            cnt_d   = '0;
            order_d = lsb_first;
        end else if (state_q == SHIFT) begin
            if (sdo_last) begin
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                if (order_q == ORDER_LSB_FIRST) begin
                    shift_d = {1'b0, shift_q[WIDTH-1:1]};
                end else begin
                    shift_d = {shift_q[WIDTH-2:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            order_q <= ORDER_MSB_FIRST;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            order_q <= order_d;
        end
    end

endmodule

// File: tb/tb_vector_serializer.sv
// Bench for vector_serializer: WIDTH=16 and WIDTH=4 instances checked
// against a queue of expected {bit,last} pairs built from each word.
module tb_vector_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [15:0] d16;
    logic        v16, o16;
    logic        r16, s16, sv16, sl16;
    logic [3:0]  d4;
    logic        v4, o4;
    logic        r4, s4, sv4, sl4;

    int checks = 0;
    int failures = 0;

    logic [1:0] q16[$];
    logic [1:0] q4[$];
    logic       acc16, acc4;

    vector_serializer #(.WIDTH(16)) u16 (
        .clk(clk), .rst_n(rst_n), .din(d16), .din_valid(v16),
        .lsb_first(o16), .din_ready(r16), .sdo(s16),
        .sdo_valid(sv16), .sdo_last(sl16)
    );

    vector_serializer #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .din(d4), .din_valid(v4),
        .lsb_first(o4), .din_ready(r4), .sdo(s4),
        .sdo_valid(sv4), .sdo_last(sl4)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // A word becomes its bits in transmit order; the last one is flagged
    function automatic void push16(input logic [15:0] w, input logic lsb);
        for (int i = 0; i < 16; i++)
            q16.push_back({lsb ? w[i] : w[15-i], i == 15});
    endfunction

    function automatic void push4(input logic [3:0] w, input logic lsb);
        for (int i = 0; i < 4; i++)
            q4.push_back({lsb ? w[i] : w[3-i], i == 3});
    endfunction

    task automatic cycle();
        @(negedge clk);
        chk("ready16", r16, rst_n && (q16.size() <= 1));
        chk("valid16", sv16, q16.size() > 0);
        chk("sdo16", s16, (q16.size() > 0) ? q16[0][1] : 1'b0);
        chk("last16", sl16, (q16.size() > 0) ? q16[0][0] : 1'b0);
        chk("ready4", r4, rst_n && (q4.size() <= 1));
        chk("valid4", sv4, q4.size() > 0);
        chk("sdo4", s4, (q4.size() > 0) ? q4[0][1] : 1'b0);
        chk("last4", sl4, (q4.size() > 0) ? q4[0][0] : 1'b0);
        acc16 = rst_n && v16 && (q16.size() <= 1);
        acc4  = rst_n && v4 && (q4.size() <= 1);
        @(posedge clk);
        if (q16.size() > 0) void'(q16.pop_front());
        if (q4.size() > 0) void'(q4.pop_front());
        if (acc16) push16(d16, o16);
        if (acc4) push4(d4, o4);
        #1;
    endtask

    task automatic wait_acc16(input int bound);
        int n = 0;
        cycle();
        while (!acc16 && n < bound) begin
            cycle();
            n++;
        end
        checks++;
        assert (acc16) else begin
            failures++;
            $error("FAIL accept_timeout observed=%0d expected<%0d", n, bound);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        d16 = '0; v16 = 1'b0; o16 = 1'b0;
        d4 = '0; v4 = 1'b0; o4 = 1'b0;
        acc16 = 1'b0; acc4 = 1'b0;
        repeat (3) cycle();
        rst_n = 1'b1;
        repeat (2) cycle();

        // MSB-first single word
        d16 = 16'h3333; o16 = 1'b0; v16 = 1'b1;
        cycle();
        v16 = 1'b0;
        repeat (18) cycle();

        // LSB-first single word
        d16 = 16'heeee; o16 = 1'b1; v16 = 1'b1;
        cycle();
        v16 = 1'b0;
        repeat (18) cycle();

        // Back-to-back: second word held until the last-bit cycle
        d16 = 16'h3333; o16 = 1'b0; v16 = 1'b1;
        cycle();
        d16 = 16'heeee; o16 = 1'b1;
        wait_acc16(40);
        v16 = 1'b0;
        repeat (18) cycle();

        // Order toggled mid-word, then a held request under backpressure
        d16 = 16'h3333; o16 = 1'b0; v16 = 1'b1;
        cycle();
        v16 = 1'b0;
        repeat (3) cycle();
        o16 = 1'b1;
        repeat (3) cycle();
        o16 = 1'b0;
        d16 = 16'h00ff; v16 = 1'b1;
        wait_acc16(40);
        v16 = 1'b0;
        repeat (18) cycle();

        // Reset in the middle of a word
        d16 = 16'hffff; o16 = 1'b0; v16 = 1'b1;
        cycle();
        v16 = 1'b0;
        repeat (5) cycle();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid16", sv16, 1'b0);
        chk("rst_sdo16", s16, 1'b0);
        chk("rst_ready16", r16, 1'b0);
        q16.delete();
        q4.delete();
        repeat (2) cycle();
        rst_n = 1'b1;
        cycle();

        d16 = 16'h8001; o16 = 1'b0; v16 = 1'b1;
        d4 = 4'hA; o4 = 1'b0; v4 = 1'b1;
        cycle();
        v16 = 1'b0; v4 = 1'b0;
        repeat (18) cycle();

        // Random traffic; requests stay stable until accepted
        for (int i = 0; i < 600; i++) begin
            if (!(v16 && !acc16)) begin
                v16 = ($urandom_range(0, 3) != 0);
                d16 = 16'($urandom);
                o16 = 1'($urandom);
            end
            if (!(v4 && !acc4)) begin
                v4 = ($urandom_range(0, 2) != 0);
                d4 = 4'($urandom);
                o4 = 1'($urandom);
            end
            cycle();
        end
        v16 = 1'b0; v4 = 1'b0;
        repeat (20) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
